// File: rtl/ca_sched_pkg.sv
// Shared types and constants for the DDR5 RCD CA rank scheduler.
package ca_sched_pkg;

    // Scheduler FSM: normal issue, pre-update quiet window, update, post-update quiet window
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_QUIET  = 2'd1,
        ST_APPLY  = 2'd2,
        ST_SETTLE = 2'd3
    } sched_state_t;

    typedef logic [1:0] rank_mask_t;

    localparam rank_mask_t MASK_NONE = 2'b00;
    localparam rank_mask_t MASK_R0   = 2'b01;
    localparam rank_mask_t MASK_R1   = 2'b10;
    localparam rank_mask_t MASK_BOTH = 2'b11;

    localparam logic [1:0] RST_DRIVE_DEFAULT = 2'b01;

endpackage

// File: rtl/ca_sched_fifo.sv
// Command buffer for the CA scheduler: synchronous FIFO of {mask, CA} entries
// with first-word-fall-through read, full/empty flags and an occupancy count.
module ca_sched_fifo
    import ca_sched_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             push_ok;
    logic             pop_ok;

    // Overflow/underflow requests are ignored so pointers can never corrupt
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign rd_data = mem[rd_ptr];

    // Entry storage: data only, no reset needed
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/ca_rank_scheduler.sv
// DDR5 RCD CA rank scheduler: buffers host CA words, issues them to one or both
// ranks with a per-rank minimum issue gap, and applies distributor configuration
// (rank_enable, drive_strength) only inside a quiet window on the CA outputs.
// Optional feature macro: CA_SCHED_PARITY_EN adds the registered even-parity
// output ca_par_out for each issued CA word.
module ca_rank_scheduler
    import ca_sched_pkg::*;
#(
    parameter int         CA_WIDTH     = 7,
    parameter int         NUM_RANKS    = 2,
    parameter int         FIFO_DEPTH   = 4,
    parameter int         GAP_CYCLES   = 2,
    parameter int         QUIET_CYCLES = 4,
    parameter logic [1:0] RST_DRIVE    = RST_DRIVE_DEFAULT
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [CA_WIDTH-1:0] cmd_ca,
    input  logic [1:0]          cmd_rank_mask,
    input  logic                cfg_valid,
    input  logic [1:0]          cfg_rank_enable,
    input  logic [1:0]          cfg_drive,
    output logic                cfg_done,
    output logic [CA_WIDTH-1:0] ca_out,
    output logic [1:0]          ca_valid_out,
    output logic [1:0]          rank_enable,
    output logic [1:0]          drive_strength,
    output logic                busy,
    output logic                err_drop
`ifdef CA_SCHED_PARITY_EN
    ,
    output logic                ca_par_out
`endif
);

    localparam int ENTRY_W = CA_WIDTH + 2;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int GAP_W   = $clog2(GAP_CYCLES + 2);
    localparam int QUIET_W = $clog2(QUIET_CYCLES + 1);

    logic                push;
    logic                pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    logic [ENTRY_W-1:0]  head;
    rank_mask_t          head_mask;
    rank_mask_t          eff_mask;
    logic [CA_WIDTH-1:0] head_ca;

    sched_state_t        state;
    logic [QUIET_W-1:0]  quiet_cnt;
    logic [GAP_W-1:0]    gap [NUM_RANKS];

    logic                gap_blocked;
    logic                can_issue;
    logic                do_issue;
    logic                do_drop;
    logic                cfg_illegal;

    ca_sched_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data ({cmd_rank_mask, cmd_ca}),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign cmd_ready = !fifo_full;
    assign push      = cmd_valid && !fifo_full;
    assign head_mask = head[ENTRY_W-1 -: 2];
    assign head_ca   = head[CA_WIDTH-1:0];
    assign eff_mask  = head_mask & rank_enable;
    assign busy      = (fifo_count != '0) || (state != ST_RUN);

    // Head is blocked if any targeted rank is still inside its issue gap
    always_comb begin
        gap_blocked = 1'b0;
        for (int i = 0; i < NUM_RANKS; i++) begin
            if (eff_mask[i] && (gap[i] != '0)) gap_blocked = 1'b1;
        end
    end

    // A pending config request wins over issue on the RUN->QUIET transition cycle
    assign can_issue   = (state == ST_RUN) && !cfg_valid && !fifo_empty;
    assign do_drop     = can_issue && (eff_mask == MASK_NONE);
    assign do_issue    = can_issue && (eff_mask != MASK_NONE) && !gap_blocked;
    assign pop         = do_drop || do_issue;
    assign cfg_illegal = (state == ST_APPLY) && (cfg_rank_enable == MASK_NONE);

    // Config FSM: RUN -> QUIET (QUIET_CYCLES) -> APPLY (1) -> SETTLE (QUIET_CYCLES) -> RUN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RUN;
            quiet_cnt <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (cfg_valid) begin
                        state     <= ST_QUIET;
                        quiet_cnt <= QUIET_W'(QUIET_CYCLES - 1);
                    end
                end
                ST_QUIET: begin
                    if (quiet_cnt == '0) state <= ST_APPLY;
                    else                 quiet_cnt <= quiet_cnt - 1'b1;
                end
                ST_APPLY: begin
                    state     <= ST_SETTLE;
                    quiet_cnt <= QUIET_W'(QUIET_CYCLES - 1);
                end
                ST_SETTLE: begin
                    if (quiet_cnt == '0) state <= ST_RUN;
                    else                 quiet_cnt <= quiet_cnt - 1'b1;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    // Distributor configuration register; an all-zero rank_enable is rejected
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rank_enable    <= MASK_BOTH;
            drive_strength <= RST_DRIVE;
            cfg_done       <= 1'b0;
        end else begin
            cfg_done <= (state == ST_APPLY);
            if (state == ST_APPLY) begin
                drive_strength <= cfg_drive;
                if (cfg_rank_enable != MASK_NONE) rank_enable <= cfg_rank_enable;
            end
        end
    end

    // Per-rank gap counters: reload on issue, otherwise saturate-decrement toward zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_RANKS; i++) gap[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_RANKS; i++) begin
                if (do_issue && eff_mask[i]) gap[i] <= GAP_W'(GAP_CYCLES);
                else if (gap[i] != '0)       gap[i] <= gap[i] - 1'b1;
            end
        end
    end

    // Registered CA outputs: strobe for one cycle per issue, word held while idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ca_out       <= '0;
            ca_valid_out <= MASK_NONE;
            err_drop     <= 1'b0;
        end else begin
            ca_valid_out <= do_issue ? eff_mask : MASK_NONE;
            err_drop     <= do_drop || cfg_illegal;
            if (do_issue) ca_out <= head_ca;
        end
    end

`ifdef CA_SCHED_PARITY_EN
    // Even parity of the issued CA word, updated in lockstep with ca_out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ca_par_out <= 1'b0;
        end else if (do_issue) begin
            ca_par_out <= ^head_ca;
        end
    end
`endif

endmodule

// File: tb/tb_ca_rank_scheduler.sv
// Directed testbench for ca_rank_scheduler (default parameters).
// Parity checks are compiled in only when CA_SCHED_PARITY_EN is defined.
module tb_ca_rank_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [6:0] cmd_ca = '0;
    logic [1:0] cmd_rank_mask = 2'b01;
    logic       cfg_valid = 1'b0;
    logic [1:0] cfg_rank_enable = 2'b11;
    logic [1:0] cfg_drive = 2'b01;
    logic       cfg_done;
    logic [6:0] ca_out;
    logic [1:0] ca_valid_out;
    logic [1:0] rank_enable;
    logic [1:0] drive_strength;
    logic       busy;
    logic       err_drop;
`ifdef CA_SCHED_PARITY_EN
    logic       ca_par_out;
`endif

    int checks = 0;
    int fails  = 0;

    ca_rank_scheduler dut (
        .clk             (clk),
        .rst             (rst),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_ca          (cmd_ca),
        .cmd_rank_mask   (cmd_rank_mask),
        .cfg_valid       (cfg_valid),
        .cfg_rank_enable (cfg_rank_enable),
        .cfg_drive       (cfg_drive),
        .cfg_done        (cfg_done),
        .ca_out          (ca_out),
        .ca_valid_out    (ca_valid_out),
        .rank_enable     (rank_enable),
        .drive_strength  (drive_strength),
        .busy            (busy),
        .err_drop        (err_drop)
`ifdef CA_SCHED_PARITY_EN
        ,
        .ca_par_out      (ca_par_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        checks++; if (ca_out !== 7'h00)        begin fails++; $display("FAIL reset_ca_out: got %h expected 00", ca_out); end
        checks++; if (ca_valid_out !== 2'b00)  begin fails++; $display("FAIL reset_ca_valid: got %b expected 00", ca_valid_out); end
        checks++; if (rank_enable !== 2'b11)   begin fails++; $display("FAIL reset_rank_enable: got %b expected 11", rank_enable); end
        checks++; if (drive_strength !== 2'b01) begin fails++; $display("FAIL reset_drive: got %b expected 01", drive_strength); end
        checks++; if (cmd_ready !== 1'b1)      begin fails++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
        checks++; if (cfg_done !== 1'b0)       begin fails++; $display("FAIL reset_cfg_done: got %b expected 0", cfg_done); end
        checks++; if (err_drop !== 1'b0)       begin fails++; $display("FAIL reset_err_drop: got %b expected 0", err_drop); end
        checks++; if (busy !== 1'b0)           begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single;
        cmd_ca = 7'h2A; cmd_rank_mask = 2'b01; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        checks++; if (busy !== 1'b1)          begin fails++; $display("FAIL single_busy_queued: got %b expected 1", busy); end
        checks++; if (ca_valid_out !== 2'b00) begin fails++; $display("FAIL single_no_early_issue: got %b expected 00", ca_valid_out); end
        tick();
        checks++; if (ca_out !== 7'h2A)       begin fails++; $display("FAIL single_ca_out: got %h expected 2a", ca_out); end
        checks++; if (ca_valid_out !== 2'b01) begin fails++; $display("FAIL single_ca_valid: got %b expected 01", ca_valid_out); end
        checks++; if (busy !== 1'b0)          begin fails++; $display("FAIL single_busy_idle: got %b expected 0", busy); end
        tick();
        checks++; if (ca_valid_out !== 2'b00) begin fails++; $display("FAIL single_strobe_one_cycle: got %b expected 00", ca_valid_out); end
        checks++; if (ca_out !== 7'h2A)       begin fails++; $display("FAIL single_ca_hold: got %h expected 2a", ca_out); end
        tick();
        tick();
    endtask

    task automatic test_gap;
        int         n = 0;
        int         got_k [3];
        logic [6:0] got_ca [3];
        logic [1:0] got_m [3];
        int         exp_k [3]  = '{1, 4, 7};
        logic [6:0] exp_ca [3] = '{7'h11, 7'h12, 7'h13};
        logic [1:0] exp_m [3]  = '{2'b01, 2'b01, 2'b11};
        for (int k = 0; k < 13; k++) begin
            case (k)
                0: begin cmd_ca = 7'h11; cmd_rank_mask = 2'b01; cmd_valid = 1'b1; end
                1: begin cmd_ca = 7'h12; cmd_rank_mask = 2'b01; end
                2: begin cmd_ca = 7'h13; cmd_rank_mask = 2'b11; end
                3: cmd_valid = 1'b0;
                default: ;
            endcase
            tick();
            if (ca_valid_out != 2'b00) begin
                if (n < 3) begin got_k[n] = k; got_ca[n] = ca_out; got_m[n] = ca_valid_out; end
                n++;
            end
        end
        checks++; if (n != 3) begin fails++; $display("FAIL gap_issue_count: got %0d expected 3", n); end
        for (int j = 0; j < 3; j++) begin
            if (j < n) begin
                checks++; if (got_k[j] != exp_k[j])    begin fails++; $display("FAIL gap_issue%0d_cycle: got %0d expected %0d", j, got_k[j], exp_k[j]); end
                checks++; if (got_ca[j] !== exp_ca[j]) begin fails++; $display("FAIL gap_issue%0d_ca: got %h expected %h", j, got_ca[j], exp_ca[j]); end
                checks++; if (got_m[j] !== exp_m[j])   begin fails++; $display("FAIL gap_issue%0d_mask: got %b expected %b", j, got_m[j], exp_m[j]); end
            end
        end
        tick();
        tick();
    endtask

    task automatic test_full;
        int bad = 0;
        cfg_rank_enable = 2'b11; cfg_drive = 2'b01; cfg_valid = 1'b1;
        tick();
        for (int p = 0; p < 4; p++) begin
            cmd_ca = 7'h30 + 7'(p); cmd_rank_mask = 2'b01; cmd_valid = 1'b1;
            tick();
            if (ca_valid_out != 2'b00) bad++;
            if (p == 2) begin
                checks++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL full_ready_at_3: got %b expected 1", cmd_ready); end
            end
            if (p == 3) begin
                checks++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL full_ready_at_4: got %b expected 0", cmd_ready); end
            end
        end
        cmd_valid = 1'b0;
        tick();
        checks++; if (cfg_done !== 1'b1)       begin fails++; $display("FAIL full_cfg_done: got %b expected 1", cfg_done); end
        checks++; if (err_drop !== 1'b0)       begin fails++; $display("FAIL full_no_err: got %b expected 0", err_drop); end
        checks++; if (rank_enable !== 2'b11)   begin fails++; $display("FAIL full_rank_enable: got %b expected 11", rank_enable); end
        cfg_valid = 1'b0;
        for (int s = 0; s < 4; s++) begin
            tick();
            if (ca_valid_out != 2'b00 || cmd_ready != 1'b0) bad++;
        end
        checks++; if (bad != 0) begin fails++; $display("FAIL full_quiet_window: got %0d bad cycles expected 0", bad); end
        tick();
        checks++; if (ca_valid_out !== 2'b01) begin fails++; $display("FAIL full_first_issue: got %b expected 01", ca_valid_out); end
        checks++; if (ca_out !== 7'h30)       begin fails++; $display("FAIL full_first_ca: got %h expected 30", ca_out); end
        checks++; if (cmd_ready !== 1'b1)     begin fails++; $display("FAIL full_ready_after_pop: got %b expected 1", cmd_ready); end
        for (int s = 0; s < 12; s++) tick();
        checks++; if (busy !== 1'b0)    begin fails++; $display("FAIL full_drained_busy: got %b expected 0", busy); end
        checks++; if (ca_out !== 7'h33) begin fails++; $display("FAIL full_last_ca: got %h expected 33", ca_out); end
    endtask

    task automatic test_cfg;
        int seen = 0;
        cfg_rank_enable = 2'b10; cfg_drive = 2'b11; cfg_valid = 1'b1;
        cmd_ca = 7'h21; cmd_rank_mask = 2'b01; cmd_valid = 1'b1;
        tick();
        if (ca_valid_out != 2'b00) seen++;
        cmd_ca = 7'h22; cmd_rank_mask = 2'b10;
        for (int k = 1; k < 12; k++) begin
            if (k == 2) cmd_valid = 1'b0;
            tick();
            if (k <= 9 && ca_valid_out != 2'b00) seen++;
            if (k == 5) begin
                checks++; if (cfg_done !== 1'b1)        begin fails++; $display("FAIL cfg_done_pulse: got %b expected 1", cfg_done); end
                checks++; if (rank_enable !== 2'b10)    begin fails++; $display("FAIL cfg_rank_enable: got %b expected 10", rank_enable); end
                checks++; if (drive_strength !== 2'b11) begin fails++; $display("FAIL cfg_drive: got %b expected 11", drive_strength); end
                cfg_valid = 1'b0;
            end
            if (k == 4) begin
                checks++; if (cfg_done !== 1'b0) begin fails++; $display("FAIL cfg_done_early: got %b expected 0", cfg_done); end
            end
            if (k == 6) begin
                checks++; if (cfg_done !== 1'b0) begin fails++; $display("FAIL cfg_done_one_cycle: got %b expected 0", cfg_done); end
            end
            if (k == 10) begin
                checks++; if (err_drop !== 1'b1)      begin fails++; $display("FAIL cfg_drop_err: got %b expected 1", err_drop); end
                checks++; if (ca_valid_out !== 2'b00) begin fails++; $display("FAIL cfg_drop_no_issue: got %b expected 00", ca_valid_out); end
            end
            if (k == 11) begin
                checks++; if (ca_valid_out !== 2'b10) begin fails++; $display("FAIL cfg_rank1_issue: got %b expected 10", ca_valid_out); end
                checks++; if (ca_out !== 7'h22)       begin fails++; $display("FAIL cfg_rank1_ca: got %h expected 22", ca_out); end
                checks++; if (err_drop !== 1'b0)      begin fails++; $display("FAIL cfg_err_one_cycle: got %b expected 0", err_drop); end
            end
        end
        checks++; if (seen != 0) begin fails++; $display("FAIL cfg_quiet_strobes: got %0d expected 0", seen); end
        tick();
        tick();
    endtask

    task automatic test_cfg_illegal;
        cfg_rank_enable = 2'b00; cfg_drive = 2'b10; cfg_valid = 1'b1;
        tick();
        for (int k = 1; k < 10; k++) begin
            tick();
            if (k == 5) begin
                checks++; if (cfg_done !== 1'b1)        begin fails++; $display("FAIL illegal_cfg_done: got %b expected 1", cfg_done); end
                checks++; if (err_drop !== 1'b1)        begin fails++; $display("FAIL illegal_err_drop: got %b expected 1", err_drop); end
                checks++; if (rank_enable !== 2'b10)    begin fails++; $display("FAIL illegal_rank_kept: got %b expected 10", rank_enable); end
                checks++; if (drive_strength !== 2'b10) begin fails++; $display("FAIL illegal_drive: got %b expected 10", drive_strength); end
                cfg_valid = 1'b0;
            end
            if (k == 8) begin
                checks++; if (busy !== 1'b1) begin fails++; $display("FAIL illegal_busy_settle: got %b expected 1", busy); end
            end
            if (k == 9) begin
                checks++; if (busy !== 1'b0) begin fails++; $display("FAIL illegal_busy_run: got %b expected 0", busy); end
            end
        end
    endtask

    task automatic test_reset_mid;
        int seen = 0;
        cfg_rank_enable = 2'b11; cfg_drive = 2'b01; cfg_valid = 1'b1;
        tick();
        for (int p = 0; p < 3; p++) begin
            cmd_ca = 7'h40 + 7'(p); cmd_rank_mask = 2'b10; cmd_valid = 1'b1;
            tick();
        end
        cmd_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        cfg_valid = 1'b0;
        checks++; if (ca_out !== 7'h00)         begin fails++; $display("FAIL rstmid_ca_out: got %h expected 00", ca_out); end
        checks++; if (ca_valid_out !== 2'b00)   begin fails++; $display("FAIL rstmid_ca_valid: got %b expected 00", ca_valid_out); end
        checks++; if (rank_enable !== 2'b11)    begin fails++; $display("FAIL rstmid_rank_enable: got %b expected 11", rank_enable); end
        checks++; if (drive_strength !== 2'b01) begin fails++; $display("FAIL rstmid_drive: got %b expected 01", drive_strength); end
        checks++; if (busy !== 1'b0)            begin fails++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        checks++; if (cmd_ready !== 1'b1)       begin fails++; $display("FAIL rstmid_cmd_ready: got %b expected 1", cmd_ready); end
        checks++; if (cfg_done !== 1'b0)        begin fails++; $display("FAIL rstmid_cfg_done: got %b expected 0", cfg_done); end
        checks++; if (err_drop !== 1'b0)        begin fails++; $display("FAIL rstmid_err_drop: got %b expected 0", err_drop); end
        tick();
        #2;
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (ca_valid_out != 2'b00) seen++;
        end
        checks++; if (seen != 0)     begin fails++; $display("FAIL rstmid_stale_issue: got %0d expected 0", seen); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy_after: got %b expected 0", busy); end
    endtask

`ifdef CA_SCHED_PARITY_EN
    task automatic test_parity;
        cmd_ca = 7'h01; cmd_rank_mask = 2'b01; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        checks++; if (ca_par_out !== 1'b1) begin fails++; $display("FAIL parity_01: got %b expected 1", ca_par_out); end
        tick(); tick(); tick();
        cmd_ca = 7'h03; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        checks++; if (ca_par_out !== 1'b0) begin fails++; $display("FAIL parity_03: got %b expected 0", ca_par_out); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_gap();
        test_full();
        test_cfg();
        test_cfg_illegal();
        test_reset_mid();
`ifdef CA_SCHED_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
